// File: rtl/sync_fifo_if.sv
// Byte-stream handshake between a producer/consumer pair and the FIFO.
// The master drives requests and write data; the slave returns status and read data.
interface sync_fifo_if #(
    parameter int DATA_W = 8
);
    logic              wrt_sig;
    logic              rd_sig;
    logic [DATA_W-1:0] din;
    logic              full_sig;
    logic              empty_sig;
    logic              over_flow;
    logic              under_flow;
    logic [DATA_W-1:0] dout;

    modport master (
        output wrt_sig, rd_sig, din,
        input  full_sig, empty_sig, over_flow, under_flow, dout
    );

    modport slave (
        input  wrt_sig, rd_sig, din,
        output full_sig, empty_sig, over_flow, under_flow, dout
    );
endinterface

// File: rtl/sync_fifo_top.sv
// Single-clock 32x8 FIFO with registered read data and one-cycle overflow/underflow pulses.
// rst_n is synchronous and active-high: a 1 at a rising edge clears all control state.
module sync_fifo_top #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W:0]   cnt;
    logic              wr_ok;
    logic              rd_ok;

    assign bus.full_sig  = (cnt == FULL_CNT);
    assign bus.empty_sig = (cnt == '0);

    // Acceptance uses the flags of the current cycle, so a full FIFO still
    // accepts a simultaneous read and an empty one still accepts a write.
    assign wr_ok = bus.wrt_sig & ~bus.full_sig;
    assign rd_ok = bus.rd_sig  & ~bus.empty_sig;

    always_ff @(posedge clk) begin
        if (!rst_n && wr_ok) begin
            mem[wp] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wp             <= '0;
            rp             <= '0;
            cnt            <= '0;
            bus.dout       <= '0;
            bus.over_flow  <= 1'b0;
            bus.under_flow <= 1'b0;
        end else begin
            bus.over_flow  <= bus.wrt_sig & bus.full_sig;
            bus.under_flow <= bus.rd_sig  & bus.empty_sig;
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (rd_ok) begin
                bus.dout <= mem[rp];
                rp       <= rp + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_fifo_top.sv
// Directed bench for sync_fifo_top: queue-based reference model compared every cycle,
// plus literal expectations for fill, drain, wrap, simultaneous access and mid-run reset.
module tb_sync_fifo_top;
    logic clk = 1'b0;
    logic rst_n;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] m_q [$];
    logic [7:0] m_dout;
    logic       m_over;
    logic       m_under;

    sync_fifo_if #(.DATA_W(8)) bus ();

    sync_fifo_top #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue, updated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        logic was_full;
        logic was_empty;
        was_full  = (m_q.size() == 32);
        was_empty = (m_q.size() == 0);
        if (rst_n === 1'b1) begin
            m_q.delete();
            m_dout  = 8'h00;
            m_over  = 1'b0;
            m_under = 1'b0;
        end else begin
            m_over  = bus.wrt_sig & was_full;
            m_under = bus.rd_sig & was_empty;
            if (bus.rd_sig && !was_empty) m_dout = m_q.pop_front();
            if (bus.wrt_sig && !was_full) m_q.push_back(bus.din);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_full",  bus.full_sig,   m_q.size() == 32);
            check("model_empty", bus.empty_sig,  m_q.size() == 0);
            check("model_over",  bus.over_flow,  m_over);
            check("model_under", bus.under_flow, m_under);
            check("model_dout",  bus.dout,       m_dout);
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        bus.wrt_sig = w;
        bus.rd_sig  = r;
        bus.din     = d;
        @(posedge clk);
        #1;
        bus.wrt_sig = 1'b0;
        bus.rd_sig  = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.wrt_sig = 1'b0;
        bus.rd_sig  = 1'b0;
        bus.din     = 8'h00;
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        rst_n  = 1'b0;
        chk_en = 1'b1;
        check("rst_empty", bus.empty_sig, 1);
        check("rst_full",  bus.full_sig,  0);
        check("rst_over",  bus.over_flow, 0);
        check("rst_under", bus.under_flow, 0);
        check("rst_dout",  bus.dout, 8'h00);

        // Fill and overflow
        for (int i = 0; i < 32; i++) cyc(1, 0, 8'(i));
        check("fill_full",  bus.full_sig,  1);
        check("fill_empty", bus.empty_sig, 0);
        cyc(1, 0, 8'hAA);
        check("ovf_pulse", bus.over_flow, 1);
        check("ovf_full",  bus.full_sig,  1);
        cyc(0, 0, 8'h00);
        check("ovf_clear", bus.over_flow, 0);

        // Drain and underflow
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 8'h00);
            check("drain_dout", bus.dout, 32'(i));
        end
        check("drain_empty", bus.empty_sig, 1);
        cyc(0, 1, 8'h00);
        check("udf_pulse", bus.under_flow, 1);
        check("udf_dout",  bus.dout, 8'h1F);
        cyc(0, 0, 8'h00);
        check("udf_clear", bus.under_flow, 0);

        // Pointer wrap
        for (int i = 0; i < 20; i++) cyc(1, 0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 8'h00);
            check("wrap_pre_dout", bus.dout, 32'(8'h20 + i));
        end
        for (int i = 0; i < 32; i++) cyc(1, 0, 8'(8'h40 + i));
        check("wrap_full", bus.full_sig, 1);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 8'h00);
            check("wrap_dout", bus.dout, 32'(8'h40 + i));
        end
        check("wrap_empty", bus.empty_sig, 1);

        // Simultaneous read+write with 5 entries
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h60 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 8'(8'h70 + i));
            check("simul_dout", bus.dout, (i < 5) ? 32'(8'h60 + i) : 32'(8'h70 + i - 5));
            check("simul_full",  bus.full_sig,  0);
            check("simul_empty", bus.empty_sig, 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 8'h00);
            check("simul_tail", bus.dout, 32'(8'h75 + i));
        end
        check("simul_drained", bus.empty_sig, 1);

        // Simultaneous on empty: write only, underflow pulse, no bypass
        cyc(1, 1, 8'h88);
        check("se_under", bus.under_flow, 1);
        check("se_empty", bus.empty_sig, 0);
        check("se_dout",  bus.dout, 8'h79);
        cyc(0, 1, 8'h00);
        check("se_read", bus.dout, 8'h88);

        // Simultaneous on full: read only, overflow pulse, din dropped
        for (int i = 0; i < 32; i++) cyc(1, 0, 8'(8'h90 + i));
        check("sf_pre_full", bus.full_sig, 1);
        cyc(1, 1, 8'hEE);
        check("sf_over", bus.over_flow, 1);
        check("sf_dout", bus.dout, 8'h90);
        check("sf_full", bus.full_sig, 0);
        for (int i = 0; i < 31; i++) begin
            cyc(0, 1, 8'h00);
            check("sf_dout_rest", bus.dout, 32'(8'h91 + i));
        end
        check("sf_empty", bus.empty_sig, 1);

        // Reset mid-run, with a write pending during the reset edge
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'hC0 + i));
        rst_n = 1'b1;
        cyc(1, 0, 8'h55);
        rst_n = 1'b0;
        check("mrst_empty", bus.empty_sig, 1);
        check("mrst_dout",  bus.dout, 8'h00);
        cyc(0, 1, 8'h00);
        check("mrst_under", bus.under_flow, 1);
        check("mrst_dout2", bus.dout, 8'h00);
        cyc(0, 0, 8'h00);

        @(posedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
